// File: rtl/score_digit_ctrl.sv
// Score digit controller: debounces three push-buttons, keeps a saturating
// 0..99 score and drives tens/ones digit codes for a two-digit 7-segment
// driver (0-9 digits, 10 blank, 11 'P'). At the win score the display
// alternates between the score and a "P " pattern.
module score_digit_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES    = 8,
    parameter int unsigned WIN_SCORE       = 21,
    parameter bit          LZ_BLANK        = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    input  logic       btn_clr_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [6:0] score_o,
    output logic       win_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [3:0]  TENS_RST = LZ_BLANK ? 4'd10 : 4'd0;

    typedef enum logic {
        S_COUNT = 1'b0,
        S_WIN   = 1'b1
    } state_t;

    // Button bit order: [0] inc, [1] dec, [2] clr
    logic [2:0]      w_btn_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_deb;
    logic [2:0]      r_evt;
    logic [DB_W-1:0] r_db_cnt [3];

    logic            w_inc;
    logic            w_dec;
    logic            w_clr;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [6:0]      r_score;
    logic [6:0]      w_score_nxt;

    logic [BL_W-1:0] r_blink_cnt;
    logic            r_phase;

    logic [6:0]      w_rem;
    logic [3:0]      w_tens_bin;
    logic [3:0]      w_ones_bin;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_nxt;

    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic            r_win;

    assign w_btn_raw = {btn_clr_i, btn_dec_i, btn_inc_i};

    // Two-flop synchronizer, stability-counter debounce and rising-edge event per button
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_evt   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                r_evt[i] <= 1'b0;
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                        r_deb[i]    <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                        // Only a press (0->1) raises an event
                        r_evt[i]    <= r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_inc = r_evt[0];
    assign w_dec = r_evt[1];
    assign w_clr = r_evt[2];

    // State and score register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_COUNT;
            r_score <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_score <= w_score_nxt;
        end
    end

    // Next score/state: clear wins, inc+dec cancel, inc frozen in WIN
    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        if (w_clr) begin
            w_score_nxt = '0;
            w_state_nxt = S_COUNT;
        end else if (w_inc && w_dec) begin
            w_score_nxt = r_score;
        end else if (w_inc) begin
            if (r_state == S_COUNT && r_score < 7'd99) begin
                w_score_nxt = r_score + 7'd1;
                if (w_score_nxt == 7'(WIN_SCORE)) begin
                    w_state_nxt = S_WIN;
                end
            end
        end else if (w_dec) begin
            if (r_score != '0) begin
                w_score_nxt = r_score - 7'd1;
            end
            w_state_nxt = S_COUNT;
        end
    end

    // Blink timer: held cleared outside WIN so it starts from zero on entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_state != S_WIN) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
    end

    // Binary to BCD by repeated subtraction of ten (at most nine steps for 0..99)
    always_comb begin
        w_rem      = r_score;
        w_tens_bin = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (w_rem >= 7'd10) begin
                w_rem      = w_rem - 7'd10;
                w_tens_bin = w_tens_bin + 4'd1;
            end
        end
        w_ones_bin = w_rem[3:0];
    end

    // Display code selection: blink pattern, leading-zero blanking, plain digits
    always_comb begin
        w_tens_nxt = w_tens_bin;
        w_ones_nxt = w_ones_bin;
        if (r_state == S_WIN && r_phase) begin
            w_tens_nxt = 4'd11;
            w_ones_nxt = 4'd10;
        end else if (LZ_BLANK && r_score < 7'd10) begin
            w_tens_nxt = 4'd10;
        end
    end

    // Registered display outputs, one edge behind score/state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tens <= TENS_RST;
            r_ones <= '0;
            r_win  <= 1'b0;
        end else begin
            r_tens <= w_tens_nxt;
            r_ones <= w_ones_nxt;
            r_win  <= (r_state == S_WIN);
        end
    end

    assign tens_o  = r_tens;
    assign ones_o  = r_ones;
    assign score_o = r_score;
    assign win_o   = r_win;

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Testbench for score_digit_ctrl: directed press table plus hand-written
// sequences for latency, glitch rejection, WIN blinking, saturation and reset.
module tb_score_digit_ctrl;

    logic       clk;
    logic       a_rst, a_inc, a_dec, a_clr;
    logic [3:0] a_tens, a_ones;
    logic [6:0] a_score;
    logic       a_win;

    logic       b_rst, b_inc, b_dec, b_clr;
    logic [3:0] b_tens, b_ones;
    logic [6:0] b_score;
    logic       b_win;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic inc;
        logic dec;
        logic clr;
        int   reps;
        int   score;
        int   tens;
        int   ones;
        int   win;
    } vec_t;

    vec_t vt [11];

    score_digit_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .BLINK_CYCLES   (8),
        .WIN_SCORE      (21),
        .LZ_BLANK       (1'b1)
    ) u_dut_a (
        .clk_i    (clk),
        .rst_i    (a_rst),
        .btn_inc_i(a_inc),
        .btn_dec_i(a_dec),
        .btn_clr_i(a_clr),
        .tens_o   (a_tens),
        .ones_o   (a_ones),
        .score_o  (a_score),
        .win_o    (a_win)
    );

    score_digit_ctrl #(
        .DEBOUNCE_CYCLES(2),
        .BLINK_CYCLES   (4096),
        .WIN_SCORE      (99),
        .LZ_BLANK       (1'b0)
    ) u_dut_b (
        .clk_i    (clk),
        .rst_i    (b_rst),
        .btn_inc_i(b_inc),
        .btn_dec_i(b_dec),
        .btn_clr_i(b_clr),
        .tens_o   (b_tens),
        .ones_o   (b_ones),
        .score_o  (b_score),
        .win_o    (b_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input int s, input int t, input int o, input int w);
        chk({name, ".score"}, 32'(a_score), 32'(s));
        chk({name, ".tens"},  32'(a_tens),  32'(t));
        chk({name, ".ones"},  32'(a_ones),  32'(o));
        chk({name, ".win"},   32'(a_win),   32'(w));
    endtask

    task automatic press_a(input logic inc, input logic dec, input logic clr);
        a_inc = inc;
        a_dec = dec;
        a_clr = clr;
        repeat (22) tick();
        a_inc = 1'b0;
        a_dec = 1'b0;
        a_clr = 1'b0;
        repeat (22) tick();
    endtask

    task automatic press_b();
        b_inc = 1'b1;
        repeat (6) tick();
        b_inc = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        bit seen;
        int ph;

        vt[0]  = '{1'b1, 1'b0, 1'b0, 1,  1,  10, 1, 0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1,  2,  10, 2, 0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1,  1,  10, 1, 0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1,  1,  10, 1, 0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1,  0,  10, 0, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1,  0,  10, 0, 0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 10, 10, 1,  0, 0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1,  9,  10, 9, 0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 11, 20, 2,  0, 0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1,  0,  10, 0, 0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 20, 20, 2,  0, 0};

        a_rst = 1'b1; a_inc = 1'b0; a_dec = 1'b0; a_clr = 1'b0;
        b_rst = 1'b1; b_inc = 1'b0; b_dec = 1'b0; b_clr = 1'b0;
        #3;
        chk_a("rst_a", 0, 10, 0, 0);
        chk("rst_b.tens", 32'(b_tens), 32'd0);
        chk("rst_b.score", 32'(b_score), 32'd0);
        chk("rst_b.win", 32'(b_win), 32'd0);
        repeat (3) tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (3) tick();
        chk_a("idle_a", 0, 10, 0, 0);

        // Glitch rejection: 5 high / 5 low never reaches the debounce count
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_inc = 1'b1;
            repeat (5) begin tick(); if (a_score != 7'd0) seen = 1'b1; end
            a_inc = 1'b0;
            repeat (5) begin tick(); if (a_score != 7'd0) seen = 1'b1; end
        end
        repeat (22) tick();
        chk("glitch_seen", 32'(seen), 32'd0);
        chk_a("glitch", 0, 10, 0, 0);

        // Press latency and single event for a 40-cycle hold
        a_inc = 1'b1;
        repeat (19) tick();
        chk("lat_pre.score", 32'(a_score), 32'd0);
        tick();
        chk("lat_edge.score", 32'(a_score), 32'd1);
        chk("lat_edge.ones", 32'(a_ones), 32'd0);
        tick();
        chk_a("lat_disp", 1, 10, 1, 0);
        repeat (19) tick();
        chk_a("hold40", 1, 10, 1, 0);
        a_inc = 1'b0;
        repeat (22) tick();
        press_a(1'b0, 1'b0, 1'b1);
        chk_a("clr_after_hold", 0, 10, 0, 0);

        // Directed press table
        for (int v = 0; v < 11; v++) begin
            for (int r = 0; r < vt[v].reps; r++) begin
                press_a(vt[v].inc, vt[v].dec, vt[v].clr);
            end
            chk_a($sformatf("vec%0d", v), vt[v].score, vt[v].tens, vt[v].ones, vt[v].win);
        end

        // Reach WIN from 20 and follow the blink pattern edge by edge
        a_inc = 1'b1;
        for (int i = 0; i < 40 && a_score != 7'd21; i++) tick();
        chk("win_reach.score", 32'(a_score), 32'd21);
        chk("win_lag.win", 32'(a_win), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            tick();
            ph = ((k - 1) / 8) % 2;
            chk($sformatf("blink%0d.tens", k), 32'(a_tens), (ph != 0) ? 32'd11 : 32'd2);
            chk($sformatf("blink%0d.ones", k), 32'(a_ones), (ph != 0) ? 32'd10 : 32'd1);
            chk($sformatf("blink%0d.win", k), 32'(a_win), 32'd1);
        end
        a_inc = 1'b0;
        repeat (22) tick();
        press_a(1'b1, 1'b0, 1'b0);
        chk("win_inc_ignored.score", 32'(a_score), 32'd21);
        chk("win_inc_ignored.win", 32'(a_win), 32'd1);

        // Decrement leaves WIN with a steady (2,0) display
        a_dec = 1'b1;
        repeat (22) tick();
        for (int k = 0; k < 12; k++) begin
            chk_a($sformatf("win_dec%0d", k), 20, 2, 0, 0);
            tick();
        end
        a_dec = 1'b0;
        repeat (22) tick();

        // Async reset while in WIN blink phase 1
        a_inc = 1'b1;
        for (int i = 0; i < 40 && a_score != 7'd21; i++) tick();
        for (int i = 0; i < 40 && a_tens != 4'd11; i++) tick();
        chk("pre_rst_win.tens", 32'(a_tens), 32'd11);
        #2 a_rst = 1'b1;
        #1;
        chk_a("rst_in_win", 0, 10, 0, 0);
        a_inc = 1'b0;
        repeat (3) tick();
        a_rst = 1'b0;
        repeat (3) tick();

        // Async reset mid-debounce with the button still held afterwards
        a_inc = 1'b1;
        repeat (10) tick();
        #2 a_rst = 1'b1;
        #1;
        chk_a("rst_mid_deb", 0, 10, 0, 0);
        #1 a_rst = 1'b0;
        repeat (19) tick();
        chk("redeb_pre.score", 32'(a_score), 32'd0);
        tick();
        chk("redeb.score", 32'(a_score), 32'd1);
        a_inc = 1'b0;
        repeat (22) tick();

        // Saturation at 99 on the second instance (no leading-zero blanking)
        for (int i = 1; i <= 99; i++) begin
            press_b();
            if (i == 9) begin
                chk("b9.tens", 32'(b_tens), 32'd0);
                chk("b9.ones", 32'(b_ones), 32'd9);
            end
        end
        chk("b99.score", 32'(b_score), 32'd99);
        chk("b99.tens", 32'(b_tens), 32'd9);
        chk("b99.ones", 32'(b_ones), 32'd9);
        chk("b99.win", 32'(b_win), 32'd1);
        press_b();
        chk("bsat.score", 32'(b_score), 32'd99);
        chk("bsat.tens", 32'(b_tens), 32'd9);
        chk("bsat.ones", 32'(b_ones), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_digit_ctrl.md
Name: score_digit_ctrl

Overview:
- Upstream stage of the scoreboard display path.
- Turns three raw push-buttons (increment, decrement, clear) into a saturating two-digit BCD score.
- Drives the tens/ones digit codes consumed by the two-digit 7-segment driver: codes 0-9 are digits, 10 is blank, 11 is 'P'.
- On reaching the win score it blinks the score against a "P" pattern until the score is cleared or decremented.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a synchronized button level is accepted (>=1).
- BLINK_CYCLES, 8, length in cycles of each blink phase while in WIN (>=1).
- WIN_SCORE, 21, binary score 1..99 at which WIN is entered.
- LZ_BLANK, 1, 1 = tens digit shows blank (code 10) when score < 10.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- btn_inc_i  in  1  raw increment button, asynchronous, active-high
- btn_dec_i  in  1  raw decrement button, asynchronous, active-high
- btn_clr_i  in  1  raw clear button, asynchronous, active-high
- tens_o  out  4  tens digit code to display driver
- ones_o  out  4  ones digit code to display driver
- score_o  out  7  current score, binary 0..99
- win_o  out  1  high while in WIN state

Behaviour:
- Reset (async assert, sync release):
  - all sync FFs, debounced levels, debounce counters and blink counter are 0
  - score = 0, state = COUNT, blink phase = 0
  - outputs: tens_o = 10 if LZ_BLANK else 0; ones_o = 0; score_o = 0; win_o = 0
- Reset mid-operation (including mid-debounce or in WIN) returns to exactly these values.
- Per button input conditioning:
  - 2-FF synchronizer.
  - Debounce: a counter runs while the synchronized level differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - A one-cycle event pulse is produced on a 0->1 transition of the debounced level. Releases produce no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Latency:
  - A button held high from clock edge N gives its event pulse at edge N+1+DEBOUNCE_CYCLES+1.
  - score_o updates at the next edge.
  - tens_o, ones_o and win_o are registered and update one edge after score_o / state.
- Event priority within one cycle:
  - clr beats everything.
  - inc and dec together cancel (no change).
- Arithmetic:
  - inc saturates at 99; dec saturates at 0; clr sets 0.
  - Score is held in binary; BCD digits are derived by tens = score/10 and ones = score%10, with no division operator in the datapath (compare/subtract or a parallel BCD counter).
- State machine:
  - COUNT -> WIN: when the updated score equals WIN_SCORE (reached by inc), same edge as the score update.
  - In WIN:
    - inc is ignored (score frozen).
    - dec decrements the score and returns to COUNT.
    - clr sets score to 0 and returns to COUNT.
  - On entering WIN, the blink counter and phase clear to 0.
- Blink:
  - In WIN, the phase toggles every BLINK_CYCLES cycles.
  - Phase 0 displays the score.
  - Phase 1 displays tens_o = 11 ('P'), ones_o = 10 (blank).
- Display mapping (COUNT, or WIN phase 0):
  - ones_o = ones digit.
  - tens_o = tens digit, except 10 when LZ_BLANK = 1 and score < 10.
  - Codes 12-15 are never driven.
- Holding a button produces exactly one event; repeat requires release (debounced 0) and a new press.

Test Plan:
- Reset, then hold inc for 40 cycles (DEBOUNCE_CYCLES = 16) -> exactly one pulse; score_o 0->1 at press+19 edges; tens_o = 10, ones_o = 1 one edge later.
- Toggle inc for 5 cycles high / 5 low repeatedly for 200 cycles -> no event; score_o stays 0.
- Preload score to 99 via 99 presses, press inc again -> score_o 99, tens_o 9, ones_o 9; press dec at 0 after clr -> score_o stays 0.
- WIN_SCORE = 21: press inc to 21 -> win_o = 1; tens/ones alternate (2,1) and (11,10) every 8 cycles; inc ignored; dec -> score 20, win_o 0, display (2,0) steady.
- Debounced inc and dec pulses in the same cycle -> score unchanged. Inc and clr in the same cycle -> score 0.
- Assert rst_i asynchronously mid-debounce and in WIN phase 1 -> outputs immediately (10,0), score 0, win 0; a held button after release needs a full debounce before it counts.
